// File: rtl/ycbcr444_to_ycbcr422_if.sv
// Video bundle for the YCbCr444 -> YCbCr422 stage: 444 stream in,
// 422 stream and sticky error flags out.
interface ycbcr444_to_ycbcr422_if #(
    parameter int WD_IMG_DATA = 8,
    parameter int WD_ERR_INFO = 4
);
    logic                   s_img_ycbcr444_c_fsync;
    logic                   s_img_ycbcr444_c_vsync;
    logic                   s_img_ycbcr444_c_hsync;
    logic [WD_IMG_DATA-1:0] s_img_ycbcr444_y_mdat0;
    logic [WD_IMG_DATA-1:0] s_img_ycbcr444_b_mdat1;
    logic [WD_IMG_DATA-1:0] s_img_ycbcr444_r_mdat2;

    logic                   m_img_ycbcr422_c_fsync;
    logic                   m_img_ycbcr422_c_vsync;
    logic                   m_img_ycbcr422_c_hsync;
    logic [WD_IMG_DATA-1:0] m_img_ycbcr422_y_mdat0;
    logic [WD_IMG_DATA-1:0] m_img_ycbcr422_c_mdat1;
    logic [WD_ERR_INFO-1:0] m_err_ycbcr_info1;

    modport master (
        output s_img_ycbcr444_c_fsync,
        output s_img_ycbcr444_c_vsync,
        output s_img_ycbcr444_c_hsync,
        output s_img_ycbcr444_y_mdat0,
        output s_img_ycbcr444_b_mdat1,
        output s_img_ycbcr444_r_mdat2,
        input  m_img_ycbcr422_c_fsync,
        input  m_img_ycbcr422_c_vsync,
        input  m_img_ycbcr422_c_hsync,
        input  m_img_ycbcr422_y_mdat0,
        input  m_img_ycbcr422_c_mdat1,
        input  m_err_ycbcr_info1
    );

    modport slave (
        input  s_img_ycbcr444_c_fsync,
        input  s_img_ycbcr444_c_vsync,
        input  s_img_ycbcr444_c_hsync,
        input  s_img_ycbcr444_y_mdat0,
        input  s_img_ycbcr444_b_mdat1,
        input  s_img_ycbcr444_r_mdat2,
        output m_img_ycbcr422_c_fsync,
        output m_img_ycbcr422_c_vsync,
        output m_img_ycbcr422_c_hsync,
        output m_img_ycbcr422_y_mdat0,
        output m_img_ycbcr422_c_mdat1,
        output m_err_ycbcr_info1
    );
endinterface

// File: rtl/ycbcr444_to_ycbcr422.sv
// YCbCr444 -> YCbCr422: chroma averaged (or decimated) over pixel
// pairs, Cb/Cr interleaved on channel 1, fixed 2-cycle latency.
module ycbcr444_to_ycbcr422 #(
    parameter int MD_SIM_ABLE   = 0,
    parameter int MD_CHROMA_AVG = 1,
    parameter int WD_IMG_DATA   = 8,
    parameter int WD_ERR_INFO   = 4
) (
    input logic i_sys_clk,
    input logic i_sys_reset,
    ycbcr444_to_ycbcr422_if.slave vid
);
    localparam int W = WD_IMG_DATA;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } phase_t;

    logic         fsync;
    logic         vsync;
    logic         hsync;
    logic [W-1:0] y_in;
    logic [W-1:0] cb_in;
    logic [W-1:0] cr_in;

    assign fsync = vid.s_img_ycbcr444_c_fsync;
    assign vsync = vid.s_img_ycbcr444_c_vsync;
    assign hsync = vid.s_img_ycbcr444_c_hsync;
    assign y_in  = vid.s_img_ycbcr444_y_mdat0;
    assign cb_in = vid.s_img_ycbcr444_b_mdat1;
    assign cr_in = vid.s_img_ycbcr444_r_mdat2;

    phase_t phase;
    phase_t phase_next;
    logic   armed;
    logic   pix_vld;

    logic         fs1;
    logic         vs1;
    logic         vld1;
    logic         even1;
    logic [W-1:0] y1;
    logic [W-1:0] cb1;
    logic [W-1:0] cr1;

    logic         fs_o;
    logic         vs_o;
    logic         hs_o;
    logic [W-1:0] y_o;
    logic [W-1:0] c_o;
    logic [W-1:0] cr_hold;

    logic [W:0]   cb_sum;
    logic [W:0]   cr_sum;
    logic [W-1:0] cb_pair;
    logic [W-1:0] cr_pair;

    logic [1:0]   err_q;
    logic [1:0]   err_next;
    logic         odd_line;
    logic         bad_sync;

    assign pix_vld = armed & hsync;

    always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            phase <= EVEN;
        end else begin
            phase <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase;
        if (!hsync) begin
            phase_next = EVEN;
        end else if (armed) begin
            phase_next = (phase == EVEN) ? ODD : EVEN;
        end
    end

    // A line cut by reset is ignored until hsync has been seen low.
    always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            armed <= 1'b0;
        end else if (!hsync) begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            fs1   <= 1'b0;
            vs1   <= 1'b0;
            vld1  <= 1'b0;
            even1 <= 1'b0;
            y1    <= '0;
            cb1   <= '0;
            cr1   <= '0;
        end else begin
            fs1  <= fsync;
            vs1  <= vsync;
            vld1 <= pix_vld;
            if (pix_vld) begin
                even1 <= (phase == EVEN);
                y1    <= y_in;
                cb1   <= cb_in;
                cr1   <= cr_in;
            end
        end
    end

    // Sums are one bit wider so 255+255 rounds to 255 instead of wrapping.
    assign cb_sum  = {1'b0, cb1} + {1'b0, cb_in} + {{W{1'b0}}, 1'b1};
    assign cr_sum  = {1'b0, cr1} + {1'b0, cr_in} + {{W{1'b0}}, 1'b1};
    assign cb_pair = (MD_CHROMA_AVG != 0) ? W'(cb_sum >> 1) : cb1;
    assign cr_pair = (MD_CHROMA_AVG != 0) ? W'(cr_sum >> 1) : cr1;

    always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            fs_o    <= 1'b0;
            vs_o    <= 1'b0;
            hs_o    <= 1'b0;
            y_o     <= '0;
            c_o     <= '0;
            cr_hold <= '0;
        end else begin
            fs_o <= fs1;
            vs_o <= vs1;
            hs_o <= vld1;
            if (vld1) begin
                y_o <= y1;
                if (!even1) begin
                    c_o <= cr_hold;
                end else if (pix_vld) begin
                    c_o     <= cb_pair;
                    cr_hold <= cr_pair;
                end else begin
                    c_o <= cb1;
                end
            end
        end
    end

    assign odd_line = vld1 & even1 & ~pix_vld;
    assign bad_sync = hsync & ~vsync;

    // Clear on fsync first so an error in the same cycle survives.
    always_comb begin
        err_next = err_q;
        if (fsync) begin
            err_next = 2'b00;
        end
        if (odd_line) begin
            err_next[0] = 1'b1;
        end
        if (bad_sync) begin
            err_next[1] = 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_next;
        end
    end

    always_comb begin
        vid.m_err_ycbcr_info1      = '0;
        vid.m_err_ycbcr_info1[1:0] = err_q;
    end

    assign vid.m_img_ycbcr422_c_fsync = fs_o;
    assign vid.m_img_ycbcr422_c_vsync = vs_o;
    assign vid.m_img_ycbcr422_c_hsync = hs_o;
    assign vid.m_img_ycbcr422_y_mdat0 = y_o;
    assign vid.m_img_ycbcr422_c_mdat1 = c_o;
endmodule

// File: tb/tb_ycbcr444_to_ycbcr422.sv
// Bench for ycbcr444_to_ycbcr422: averaging and decimating instances
// share stimulus; a monitor checks each against its expected queue.
module tb_ycbcr444_to_ycbcr422;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ycbcr444_to_ycbcr422_if #(.WD_IMG_DATA(8), .WD_ERR_INFO(4)) ia ();
    ycbcr444_to_ycbcr422_if #(.WD_IMG_DATA(8), .WD_ERR_INFO(4)) ib ();

    ycbcr444_to_ycbcr422 #(
        .MD_SIM_ABLE(0), .MD_CHROMA_AVG(1),
        .WD_IMG_DATA(8), .WD_ERR_INFO(4)
    ) dut_avg (
        .i_sys_clk(clk), .i_sys_reset(rst), .vid(ia.slave)
    );

    ycbcr444_to_ycbcr422 #(
        .MD_SIM_ABLE(0), .MD_CHROMA_AVG(0),
        .WD_IMG_DATA(8), .WD_ERR_INFO(4)
    ) dut_dec (
        .i_sys_clk(clk), .i_sys_reset(rst), .vid(ib.slave)
    );

    typedef struct {
        logic [7:0] y;
        logic [7:0] c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad = 0;
    int   hs_cnt_a = 0;
    int   cnt0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic fs, vs, hs,
                         input logic [7:0] y, cb, cr);
        ia.s_img_ycbcr444_c_fsync = fs;
        ia.s_img_ycbcr444_c_vsync = vs;
        ia.s_img_ycbcr444_c_hsync = hs;
        ia.s_img_ycbcr444_y_mdat0 = y;
        ia.s_img_ycbcr444_b_mdat1 = cb;
        ia.s_img_ycbcr444_r_mdat2 = cr;
        ib.s_img_ycbcr444_c_fsync = fs;
        ib.s_img_ycbcr444_c_vsync = vs;
        ib.s_img_ycbcr444_c_hsync = hs;
        ib.s_img_ycbcr444_y_mdat0 = y;
        ib.s_img_ycbcr444_b_mdat1 = cb;
        ib.s_img_ycbcr444_r_mdat2 = cr;
    endtask

    task automatic idle(input int n, input logic fs = 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(fs && i == 0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        end
    endtask

    task automatic pix(input logic [7:0] y, cb, cr, ca, cd,
                       input logic fs = 1'b0, vs = 1'b1);
        exp_t e;
        @(negedge clk);
        drive(fs, vs, 1'b1, y, cb, cr);
        e.y = y;
        e.c = ca;
        qa.push_back(e);
        e.c = cd;
        qb.push_back(e);
    endtask

    task automatic raw(input logic [7:0] y);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, y, y, y);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ia.m_img_ycbcr422_c_hsync) begin
            hs_cnt_a++;
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL avg_extra: got y=%0d c=%0d want none",
                         ia.m_img_ycbcr422_y_mdat0,
                         ia.m_img_ycbcr422_c_mdat1);
            end else begin
                e = qa.pop_front();
                if (ia.m_img_ycbcr422_y_mdat0 !== e.y ||
                    ia.m_img_ycbcr422_c_mdat1 !== e.c) begin
                    bad++;
                    $display("FAIL avg_pix: got y=%0d c=%0d want y=%0d c=%0d",
                             ia.m_img_ycbcr422_y_mdat0,
                             ia.m_img_ycbcr422_c_mdat1, e.y, e.c);
                end
            end
        end
        if (ib.m_img_ycbcr422_c_hsync) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL dec_extra: got y=%0d c=%0d want none",
                         ib.m_img_ycbcr422_y_mdat0,
                         ib.m_img_ycbcr422_c_mdat1);
            end else begin
                e = qb.pop_front();
                if (ib.m_img_ycbcr422_y_mdat0 !== e.y ||
                    ib.m_img_ycbcr422_c_mdat1 !== e.c) begin
                    bad++;
                    $display("FAIL dec_pix: got y=%0d c=%0d want y=%0d c=%0d",
                             ib.m_img_ycbcr422_y_mdat0,
                             ib.m_img_ycbcr422_c_mdat1, e.y, e.c);
                end
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        chk("rst_hs", 32'(ia.m_img_ycbcr422_c_hsync), 0);
        chk("rst_y", 32'(ia.m_img_ycbcr422_y_mdat0), 0);
        chk("rst_c", 32'(ia.m_img_ycbcr422_c_mdat1), 0);
        chk("rst_err", 32'(ia.m_err_ycbcr_info1), 0);
        rst = 1'b0;
        idle(3);

        // Frame start: fsync/vsync appear exactly two cycles later.
        idle(1, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        chk("fsync_d1", 32'(ia.m_img_ycbcr422_c_fsync), 0);
        @(negedge clk);
        chk("fsync_d2", 32'(ia.m_img_ycbcr422_c_fsync), 1);
        chk("vsync_d2", 32'(ia.m_img_ycbcr422_c_vsync), 1);
        idle(2);

        cnt0 = hs_cnt_a;
        pix(10, 100, 50, 101, 100);
        pix(20, 102, 60, 55, 50);
        pix(30, 200, 70, 201, 200);
        pix(40, 201, 71, 71, 70);
        idle(4);
        chk("hs_len4", 32'(hs_cnt_a - cnt0), 4);
        chk("err_clean", 32'(ia.m_err_ycbcr_info1), 0);

        pix(1, 10, 30, 15, 10);
        pix(2, 20, 40, 35, 30);
        pix(3, 90, 50, 90, 90);
        idle(4);
        chk("odd_err_a", 32'(ia.m_err_ycbcr_info1), 1);
        chk("odd_err_b", 32'(ib.m_err_ycbcr_info1), 1);
        idle(1, 1'b1);
        idle(2);
        chk("odd_clr", 32'(ia.m_err_ycbcr_info1), 0);

        pix(5, 255, 0, 255, 255);
        pix(6, 255, 1, 1, 0);
        idle(4);

        // Reset in mid-line; the line must not resume after release.
        raw(8'd99);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_hs", 32'(ia.m_img_ycbcr422_c_hsync), 0);
        chk("mid_y", 32'(ia.m_img_ycbcr422_y_mdat0), 0);
        chk("mid_c", 32'(ia.m_img_ycbcr422_c_mdat1), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt0 = hs_cnt_a;
        raw(8'd98);
        raw(8'd97);
        raw(8'd96);
        idle(3);
        chk("unarmed_hs", 32'(hs_cnt_a - cnt0), 0);
        pix(7, 40, 60, 41, 40);
        pix(8, 41, 62, 61, 60);
        idle(4);

        pix(9, 77, 12, 77, 77, 1'b0, 1'b0);
        idle(4);
        chk("vs_err", 32'(ia.m_err_ycbcr_info1), 3);
        idle(1, 1'b1);
        idle(2);
        chk("vs_clr", 32'(ia.m_err_ycbcr_info1), 0);
        pix(11, 33, 44, 33, 33, 1'b1, 1'b0);
        idle(4);
        chk("fs_vs_err", 32'(ia.m_err_ycbcr_info1), 3);
        chk("fs_vs_err_b", 32'(ib.m_err_ycbcr_info1), 3);

        idle(5);
        chk("qa_empty", 32'(qa.size()), 0);
        chk("qb_empty", 32'(qb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
